// File: rtl/bitmap_slot_allocator_pkg.sv
// Shared constants for the slot allocator.
// Default width for tag/slot bitmaps.
package bitmap_slot_allocator_pkg;

    localparam int DEFAULT_WORD_WIDTH = 8;

endpackage

// File: rtl/Bitmask_1_Bit_at_Rightmost_0_Bit.sv
// Library block: one-hot mask of the rightmost 0 bit of a word.
// All-ones input yields an all-zero mask.
module Bitmask_1_Bit_at_Rightmost_0_Bit #(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] word_in,
    output logic [WORD_WIDTH-1:0] word_out
);

    localparam logic [WORD_WIDTH-1:0] ONE = {{WORD_WIDTH-1{1'b0}}, 1'b1};

    // Carry out of the trailing ones lands on the first 0 bit.
    assign word_out = ~word_in & (word_in + ONE);

endmodule

// File: rtl/bitmap_slot_allocator.sv
// Bitmap slot allocator: offers the lowest free slot, accepts multi-hot
// releases, flags releases of slots that were not occupied.
module bitmap_slot_allocator
    import bitmap_slot_allocator_pkg::*;
#(
    parameter int                     WORD_WIDTH    = DEFAULT_WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0]  INIT_OCCUPIED = {WORD_WIDTH{1'b0}}
) (
    input  logic                  clock,
    input  logic                  clear,
    output logic                  alloc_valid,
    input  logic                  alloc_ready,
    output logic [WORD_WIDTH-1:0] alloc_slot,
    input  logic                  release_valid,
    input  logic [WORD_WIDTH-1:0] release_mask,
    output logic [WORD_WIDTH-1:0] occupied,
    output logic                  full,
    output logic                  empty,
    output logic                  release_error
);

    logic [WORD_WIDTH-1:0] occ;
    logic [WORD_WIDTH-1:0] grant;
    logic [WORD_WIDTH-1:0] rel;
    logic                  err_q;

    Bitmask_1_Bit_at_Rightmost_0_Bit #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_pick (
        .word_in  (occ),
        .word_out (alloc_slot)
    );

    assign alloc_valid   = |(~occ);
    assign full          = &occ;
    assign empty         = ~|occ;
    assign occupied      = occ;
    assign release_error = err_q;

    assign grant = (alloc_valid && alloc_ready) ? alloc_slot : '0;
    assign rel   = release_valid ? release_mask : '0;

    // Grant is ORed last so a bogus release of the granted bit loses.
    always_ff @(posedge clock) begin
        if (clear) begin
            occ   <= INIT_OCCUPIED;
            err_q <= 1'b0;
        end else begin
            occ   <= (occ & ~rel) | grant;
            err_q <= |(rel & ~occ);
        end
    end

endmodule

// File: tb/tb_bitmap_slot_allocator.sv
// Scoreboard bench for bitmap_slot_allocator (WORD_WIDTH=8).
module tb_bitmap_slot_allocator;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] occ;
        logic         err;
    } exp_t;

    logic         clock = 1'b0;
    logic         clear, alloc_ready, release_valid;
    logic [W-1:0] release_mask;
    logic         alloc_valid, full, empty, release_error;
    logic [W-1:0] alloc_slot, occupied;

    logic         clear_b, alloc_ready_b, release_valid_b;
    logic [W-1:0] release_mask_b;
    logic         alloc_valid_b, full_b, empty_b, release_error_b;
    logic [W-1:0] alloc_slot_b, occupied_b;

    exp_t         q[$];
    logic [W-1:0] m_occ;
    int           total  = 0;
    int           passed = 0;

    always #5 clock = ~clock;

    bitmap_slot_allocator #(.WORD_WIDTH(W)) dut (
        .clock         (clock),
        .clear         (clear),
        .alloc_valid   (alloc_valid),
        .alloc_ready   (alloc_ready),
        .alloc_slot    (alloc_slot),
        .release_valid (release_valid),
        .release_mask  (release_mask),
        .occupied      (occupied),
        .full          (full),
        .empty         (empty),
        .release_error (release_error)
    );

    bitmap_slot_allocator #(.WORD_WIDTH(W), .INIT_OCCUPIED(8'h81)) dut_b (
        .clock         (clock),
        .clear         (clear_b),
        .alloc_valid   (alloc_valid_b),
        .alloc_ready   (alloc_ready_b),
        .alloc_slot    (alloc_slot_b),
        .release_valid (release_valid_b),
        .release_mask  (release_mask_b),
        .occupied      (occupied_b),
        .full          (full_b),
        .empty         (empty_b),
        .release_error (release_error_b)
    );

    function automatic logic [W-1:0] lowest_free(input logic [W-1:0] o);
        logic [W-1:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--)
            if (!o[i]) r = W'(1) << i;
        return r;
    endfunction

    // Reference model: bit-by-bit update, result queued for the monitor.
    task automatic drive_cycle(input logic clr, input logic rdy,
                               input logic rv, input logic [W-1:0] mask);
        logic [W-1:0] g;
        exp_t         e;
        clear         = clr;
        alloc_ready   = rdy;
        release_valid = rv;
        release_mask  = mask;
        if (clr) begin
            e.occ = '0;
            e.err = 1'b0;
        end else begin
            g     = rdy ? lowest_free(m_occ) : '0;
            e.err = 1'b0;
            for (int i = 0; i < W; i++) begin
                if (g[i])
                    e.occ[i] = 1'b1;
                else if (rv && mask[i])
                    e.occ[i] = 1'b0;
                else
                    e.occ[i] = m_occ[i];
                if (rv && mask[i] && !m_occ[i]) e.err = 1'b1;
            end
        end
        m_occ = e.occ;
        q.push_back(e);
        @(posedge clock);
        #2;
    endtask

    always @(posedge clock) begin : monitor
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            total++;
            if (occupied !== e.occ)
                $display("FAIL occ: got %h want %h", occupied, e.occ);
            else passed++;
            total++;
            if (release_error !== e.err)
                $display("FAIL err: got %b want %b", release_error, e.err);
            else passed++;
            total++;
            if (alloc_slot !== lowest_free(e.occ))
                $display("FAIL slot: got %h want %h", alloc_slot,
                         lowest_free(e.occ));
            else passed++;
            total++;
            if (full !== (e.occ == '1) || empty !== (e.occ == '0)
                || alloc_valid !== (e.occ != '1))
                $display("FAIL flags: got f%b e%b v%b for occ %h",
                         full, empty, alloc_valid, e.occ);
            else passed++;
            total++;
            if (!$onehot0(alloc_slot) || ((alloc_slot == '0) !== full))
                $display("FAIL onehot: got slot %h full %b", alloc_slot, full);
            else passed++;
        end
    end

    task automatic test_reset();
        drive_cycle(1'b1, 1'b1, 1'b1, 8'hFF);
        total++;
        if (alloc_slot !== 8'h01 || alloc_valid !== 1'b1 ||
            empty !== 1'b1 || full !== 1'b0)
            $display("FAIL reset: got slot %h v%b e%b f%b want 01 1 1 0",
                     alloc_slot, alloc_valid, empty, full);
        else passed++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < W; i++) begin
            total++;
            if (alloc_slot !== (W'(1) << i))
                $display("FAIL fill_%0d: got %h want %h", i, alloc_slot,
                         W'(1) << i);
            else passed++;
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
        end
        total++;
        if (occupied !== 8'hFF || full !== 1'b1 || alloc_valid !== 1'b0 ||
            alloc_slot !== 8'h00)
            $display("FAIL fill_end: got occ %h f%b v%b slot %h",
                     occupied, full, alloc_valid, alloc_slot);
        else passed++;
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        total++;
        if (occupied !== 8'hFF)
            $display("FAIL full_noop: got %h want ff", occupied);
        else passed++;
    endtask

    task automatic test_hole_refill();
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h14);
        total++;
        if (occupied !== 8'hEB || alloc_slot !== 8'h04)
            $display("FAIL hole: got occ %h slot %h want eb 04",
                     occupied, alloc_slot);
        else passed++;
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        total++;
        if (alloc_slot !== 8'h10)
            $display("FAIL hole_next: got %h want 10", alloc_slot);
        else passed++;
    endtask

    task automatic test_full_release();
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        repeat (W) drive_cycle(1'b0, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, 1'b1, 1'b1, 8'h80);
        total++;
        if (occupied !== 8'h7F || alloc_valid !== 1'b1 || alloc_slot !== 8'h80)
            $display("FAIL full_rel: got occ %h v%b slot %h want 7f 1 80",
                     occupied, alloc_valid, alloc_slot);
        else passed++;
    endtask

    task automatic test_simultaneous();
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        repeat (4) drive_cycle(1'b0, 1'b1, 1'b0, '0);
        total++;
        if (alloc_slot !== 8'h10)
            $display("FAIL sim_grant: got %h want 10", alloc_slot);
        else passed++;
        drive_cycle(1'b0, 1'b1, 1'b1, 8'h01);
        total++;
        if (occupied !== 8'h1E || alloc_slot !== 8'h01)
            $display("FAIL sim: got occ %h slot %h want 1e 01",
                     occupied, alloc_slot);
        else passed++;
    endtask

    task automatic test_bad_release();
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        repeat (2) drive_cycle(1'b0, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h06);
        total++;
        if (occupied !== 8'h01 || release_error !== 1'b1)
            $display("FAIL bad_rel: got occ %h err %b want 01 1",
                     occupied, release_error);
        else passed++;
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
        total++;
        if (release_error !== 1'b0)
            $display("FAIL bad_rel_pulse: got %b want 0", release_error);
        else passed++;
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h01);
        total++;
        if (occupied !== 8'h00 || release_error !== 1'b1)
            $display("FAIL empty_rel: got occ %h err %b want 00 1",
                     occupied, release_error);
        else passed++;
    endtask

    task automatic test_clear_mid();
        clear_b = 1'b1;
        @(posedge clock); #2;
        clear_b       = 1'b0;
        alloc_ready_b = 1'b1;
        repeat (6) begin @(posedge clock); #2; end
        alloc_ready_b   = 1'b0;
        release_valid_b = 1'b1;
        release_mask_b  = 8'h80;
        @(posedge clock); #2;
        total++;
        if (occupied_b !== 8'h7F)
            $display("FAIL clr_pre: got %h want 7f", occupied_b);
        else passed++;
        clear_b         = 1'b1;
        alloc_ready_b   = 1'b1;
        release_mask_b  = 8'h01;
        @(posedge clock); #2;
        clear_b         = 1'b0;
        alloc_ready_b   = 1'b0;
        release_valid_b = 1'b0;
        total++;
        if (occupied_b !== 8'h81 || alloc_slot_b !== 8'h02 ||
            release_error_b !== 1'b0 || empty_b !== 1'b0)
            $display("FAIL clr_mid: got occ %h slot %h err %b e%b",
                     occupied_b, alloc_slot_b, release_error_b, empty_b);
        else passed++;
    endtask

    task automatic test_random();
        logic         clr, rdy, rv;
        logic [W-1:0] mask;
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        for (int n = 0; n < 10000; n++) begin
            clr  = ($urandom_range(0, 199) == 0);
            rdy  = 1'($urandom_range(0, 1));
            rv   = ($urandom_range(0, 2) == 0);
            mask = 8'($urandom) &
                   (($urandom_range(0, 3) == 0) ? 8'hFF : m_occ);
            drive_cycle(clr, rdy, rv, mask);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        clear           = 1'b0;
        alloc_ready     = 1'b0;
        release_valid   = 1'b0;
        release_mask    = '0;
        clear_b         = 1'b0;
        alloc_ready_b   = 1'b0;
        release_valid_b = 1'b0;
        release_mask_b  = '0;
        @(posedge clock); #2;
        test_reset();
        test_fill();
        test_hole_refill();
        test_full_release();
        test_simultaneous();
        test_bad_release();
        test_clear_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
